// File: rtl/tinker_mem_pkg.sv
// -----------------------------------------------------------------------------
// tinker_mem_pkg
// Types and defaults shared by the memory-port arbiter and its selector.
//   arb_state_t : arbiter FSM state (IDLE, WAIT)
//   owner_t     : requester that owns the outstanding access (OWN_IF, OWN_DM)
//   MEM_LATENCY_DEF / STARVE_LIMIT_DEF : default parameter values
//   LAT_W / STARVE_W : counter widths sized for the legal parameter ranges
// -----------------------------------------------------------------------------
package tinker_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int unsigned MEM_LATENCY_DEF  = 1;
    localparam int unsigned STARVE_LIMIT_DEF = 2;

    // MEM_LATENCY is 1..15, so the down-counter needs 4 bits.
    localparam int unsigned LAT_W    = 4;
    // STARVE_LIMIT is 1..7, so the starve counter needs 3 bits.
    localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/mem_arb_select.sv
// -----------------------------------------------------------------------------
// mem_arb_select
// Winner selection between instruction fetch and data requests.
// Data has priority over fetch. With MEM_ARB_STARVE_GUARD_EN defined, a
// starve counter tracks consecutive data grants taken while fetch waits;
// once it reaches STARVE_LIMIT, fetch wins the next arbitration.
//
// Ports
//   clk      in  : clock
//   reset    in  : synchronous active-high reset
//   grant_en in  : arbitration allowed this cycle (FSM idle, not in reset)
//   if_req   in  : fetch request
//   dm_req   in  : data request
//   if_win   out : fetch granted this cycle
//   dm_win   out : data granted this cycle
//
// Configuration macro: MEM_ARB_STARVE_GUARD_EN
// -----------------------------------------------------------------------------
module mem_arb_select
    import tinker_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_win,
    output logic dm_win
);

`ifdef MEM_ARB_STARVE_GUARD_EN

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                starve_hit;

    always_comb begin
        // Fetch overrides data only while it is actually waiting.
        starve_hit   = if_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
        dm_win       = grant_en && dm_req && !starve_hit;
        if_win       = grant_en && if_req && !(dm_req && !starve_hit);

        starve_cnt_d = starve_cnt_q;
        if (if_win) begin
            starve_cnt_d = '0;
        end else if (dm_win) begin
            starve_cnt_d = if_req ? (starve_cnt_q + 1'b1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`else

    // Strict data-over-fetch priority; no state is kept.
    logic unused_guard;
    assign unused_guard = clk ^ reset ^ (STARVE_LIMIT == 0);

    always_comb begin
        dm_win = grant_en && dm_req;
        if_win = grant_en && if_req && !dm_req;
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one fixed-latency memory port between instruction fetch and data
// requests. A grant in IDLE launches the access combinationally and moves the
// FSM to WAIT; the owner's rvalid pulses MEM_LATENCY cycles later and the FSM
// is back in IDLE on the following cycle (one access per MEM_LATENCY+1).
//
// Parameters
//   MEM_LATENCY  : cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_LIMIT : consecutive data grants while fetch pends (1..7)
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request and byte address
//   if_gnt/if_rvalid/if_rdata     : fetch accept pulse, data pulse, word
//   dm_req/dm_we/dm_addr/dm_wdata : data request, write flag, address, data
//   dm_gnt/dm_rvalid/dm_rdata     : data accept pulse, done pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : shared memory port
//   busy                          : access outstanding
//
// Configuration macro: MEM_ARB_STARVE_GUARD_EN (enables fetch starve guard)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = MEM_LATENCY_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [63:0] dm_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,

    output logic        busy
);

    arb_state_t       state_q,   state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    owner_t           owner_q,   owner_d;
    logic             store_q,   store_d;

    logic grant_en;
    logic if_win;
    logic dm_win;
    logic any_win;
    logic rvalid_cyc;

    // Reset gates the combinational outputs so nothing is granted or
    // reported in a reset cycle, even though state only clears at the edge.
    assign grant_en = (state_q == IDLE) && !reset;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .grant_en (grant_en),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .if_win   (if_win),
        .dm_win   (dm_win)
    );

    assign any_win = if_win | dm_win;
    assign if_gnt  = if_win;
    assign dm_gnt  = dm_win;
    assign mem_en  = any_win;

    // Memory command is driven straight from the winner in the grant cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_win) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_win) begin
            mem_addr  = if_addr;
        end
    end

    assign rvalid_cyc = (state_q == WAIT) && (lat_cnt_q == '0) && !reset;
    assign busy       = (state_q == WAIT) && !reset;

    // Response routed only to the latched owner; stores return zero data.
    assign if_rvalid = rvalid_cyc && (owner_q == OWN_IF);
    assign dm_rvalid = rvalid_cyc && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata[31:0] : '0;
    assign dm_rdata  = (dm_rvalid && !store_q) ? mem_rdata : '0;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        store_d   = store_q;
        case (state_q)
            IDLE: begin
                if (any_win) begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
                    owner_d   = dm_win ? OWN_DM : OWN_IF;
                    store_d   = dm_win && dm_we;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            owner_q   <= OWN_IF;
            store_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            owner_q   <= owner_d;
            store_q   <= store_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Instance A uses MEM_LATENCY=1,
// instance B uses MEM_LATENCY=3; both use STARVE_LIMIT=2. Starve-order
// expectations follow MEM_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] A_RDATA = 64'h1122_3344_5566_7788;
    localparam logic [63:0] B_RDATA = 64'hA5A5_0000_5A5A_FFFF;

    logic        a_reset, a_if_req, a_if_gnt, a_if_rvalid;
    logic [63:0] a_if_addr;
    logic [31:0] a_if_rdata;
    logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
    logic [63:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [63:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_reset, b_if_req, b_if_gnt, b_if_rvalid;
    logic [63:0] b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
    logic [63:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(2)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
        .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid),
        .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(2)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid),
        .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units
    // later, well before the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    bit [5:0] if_order;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_if_req = 1'b0; a_if_addr = '0; a_dm_req = 1'b0; a_dm_we = 1'b0;
        a_dm_addr = '0; a_dm_wdata = '0; a_mem_rdata = A_RDATA;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = B_RDATA;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if_order = 6'b100100;
`else
        if_order = 6'b000000;
`endif
        next_cycle();
        next_cycle();

        // Request presented during reset must not be granted.
        a_dm_req = 1'b1; a_dm_addr = 64'h2100;
        #2;
        check_eq("rst_dm_gnt",   64'(a_dm_gnt),    64'd0);
        check_eq("rst_mem_en",   64'(a_mem_en),    64'd0);
        check_eq("rst_mem_addr", a_mem_addr,       64'd0);
        check_eq("rst_busy",     64'(a_busy),      64'd0);
        check_eq("rst_rvalid",   64'(a_dm_rvalid), 64'd0);
        check_eq("rst_rdata",    a_dm_rdata,       64'd0);

        // Load at 0x2100, granted in the first cycle after reset release.
        next_cycle();
        a_reset = 1'b0; b_reset = 1'b0;
        #2;
        check_eq("ld_dm_gnt",   64'(a_dm_gnt), 64'd1);
        check_eq("ld_if_gnt",   64'(a_if_gnt), 64'd0);
        check_eq("ld_mem_en",   64'(a_mem_en), 64'd1);
        check_eq("ld_mem_we",   64'(a_mem_we), 64'd0);
        check_eq("ld_mem_addr", a_mem_addr,    64'h2100);
        next_cycle();
        a_dm_req = 1'b0;
        #2;
        check_eq("ld_rvalid",    64'(a_dm_rvalid), 64'd1);
        check_eq("ld_rdata",     a_dm_rdata,       A_RDATA);
        check_eq("ld_if_rvalid", 64'(a_if_rvalid), 64'd0);
        check_eq("ld_busy",      64'(a_busy),      64'd1);
        check_eq("ld_mem_en_w",  64'(a_mem_en),    64'd0);
        next_cycle();
        #2;
        check_eq("ld_idle_busy",   64'(a_busy),      64'd0);
        check_eq("ld_idle_rvalid", 64'(a_dm_rvalid), 64'd0);
        check_eq("noreq_mem_en",   64'(a_mem_en),    64'd0);

        // Simultaneous fetch and data: data first, fetch next idle cycle.
        next_cycle();
        a_if_req = 1'b1; a_if_addr = 64'h2000;
        a_dm_req = 1'b1; a_dm_addr = 64'h2200; a_dm_we = 1'b0;
        #2;
        check_eq("sim_dm_gnt",   64'(a_dm_gnt), 64'd1);
        check_eq("sim_if_gnt",   64'(a_if_gnt), 64'd0);
        check_eq("sim_mem_addr", a_mem_addr,    64'h2200);
        next_cycle();
        a_dm_req = 1'b0;
        #2;
        check_eq("sim_dm_rvalid", 64'(a_dm_rvalid), 64'd1);
        check_eq("sim_if_gnt_w",  64'(a_if_gnt),    64'd0);
        check_eq("sim_if_rv_w",   64'(a_if_rvalid), 64'd0);
        next_cycle();
        #2;
        check_eq("sim_if_gnt2",  64'(a_if_gnt), 64'd1);
        check_eq("sim_dm_gnt2",  64'(a_dm_gnt), 64'd0);
        check_eq("sim_if_addr",  a_mem_addr,    64'h2000);
        check_eq("sim_if_we",    64'(a_mem_we), 64'd0);
        next_cycle();
        a_if_req = 1'b0;
        #2;
        check_eq("if_rvalid",    64'(a_if_rvalid),  64'd1);
        check_eq("if_rdata",     64'(a_if_rdata),   64'h5566_7788);
        check_eq("if_dm_rvalid", 64'(a_dm_rvalid),  64'd0);
        check_eq("if_dm_rdata",  a_dm_rdata,        64'd0);
        next_cycle();
        #2;
        check_eq("if_idle_busy", 64'(a_busy), 64'd0);

        // Store of 0xDEADBEEF_00000001 to 0x3000.
        next_cycle();
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 64'h3000;
        a_dm_wdata = 64'hDEAD_BEEF_0000_0001;
        #2;
        check_eq("st_dm_gnt",    64'(a_dm_gnt), 64'd1);
        check_eq("st_mem_we",    64'(a_mem_we), 64'd1);
        check_eq("st_mem_addr",  a_mem_addr,    64'h3000);
        check_eq("st_mem_wdata", a_mem_wdata,   64'hDEAD_BEEF_0000_0001);
        next_cycle();
        a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_wdata = '0;
        #2;
        check_eq("st_rvalid", 64'(a_dm_rvalid), 64'd1);
        check_eq("st_rdata",  a_dm_rdata,       64'd0);
        next_cycle();
        #2;
        check_eq("st_idle_busy", 64'(a_busy), 64'd0);

        // Both requests held: order depends on the starve guard.
        next_cycle();
        a_dm_req = 1'b1; a_dm_addr = 64'h5000;
        a_if_req = 1'b1; a_if_addr = 64'h6000;
        for (int k = 0; k < 6; k++) begin
            #2;
            check_eq($sformatf("ord%0d_if_gnt", k), 64'(a_if_gnt), 64'(if_order[k]));
            check_eq($sformatf("ord%0d_dm_gnt", k), 64'(a_dm_gnt), 64'(!if_order[k]));
            check_eq($sformatf("ord%0d_addr", k), a_mem_addr,
                     if_order[k] ? 64'h6000 : 64'h5000);
            next_cycle();
            #2;
            check_eq($sformatf("ord%0d_if_rv", k), 64'(a_if_rvalid), 64'(if_order[k]));
            check_eq($sformatf("ord%0d_dm_rv", k), 64'(a_dm_rvalid), 64'(!if_order[k]));
            check_eq($sformatf("ord%0d_nognt", k), 64'(a_if_gnt | a_dm_gnt), 64'd0);
            next_cycle();
        end
        a_dm_req = 1'b0; a_if_req = 1'b0;
        #2;
        check_eq("ord_end_busy", 64'(a_busy), 64'd0);

        // Latency 3: reset one cycle into WAIT abandons the access.
        next_cycle();
        b_dm_req = 1'b1; b_dm_addr = 64'h4000;
        #2;
        check_eq("b_gnt0",      64'(b_dm_gnt),    64'd1);
        check_eq("b_mem_en0",   64'(b_mem_en),    64'd1);
        check_eq("b_mem_addr0", b_mem_addr,       64'h4000);
        check_eq("b_mem_we0",   64'(b_mem_we),    64'd0);
        check_eq("b_wdata0",    b_mem_wdata,      64'd0);
        check_eq("b_if_gnt0",   64'(b_if_gnt),    64'd0);
        next_cycle();
        b_dm_req = 1'b0; b_reset = 1'b1;
        #2;
        check_eq("b_rst_rvalid", 64'(b_dm_rvalid), 64'd0);
        check_eq("b_rst_gnt",    64'(b_dm_gnt),    64'd0);
        next_cycle();
        b_reset = 1'b0; b_dm_req = 1'b1; b_dm_addr = 64'h4100;
        #2;
        check_eq("b_post_busy",   64'(b_busy),      64'd0);
        check_eq("b_post_rvalid", 64'(b_dm_rvalid), 64'd0);
        check_eq("b_post_gnt",    64'(b_dm_gnt),    64'd1);
        check_eq("b_post_addr",   b_mem_addr,       64'h4100);
        next_cycle();
        b_dm_req = 1'b0;
        #2;
        check_eq("b_lat1_rvalid", 64'(b_dm_rvalid), 64'd0);
        check_eq("b_lat1_busy",   64'(b_busy),      64'd1);
        next_cycle();
        #2;
        check_eq("b_lat2_rvalid", 64'(b_dm_rvalid), 64'd0);
        next_cycle();
        #2;
        check_eq("b_lat3_rvalid", 64'(b_dm_rvalid), 64'd1);
        check_eq("b_lat3_rdata",  b_dm_rdata,       B_RDATA);
        check_eq("b_lat3_if_rv",  64'(b_if_rvalid), 64'd0);
        check_eq("b_lat3_if_rd",  64'(b_if_rdata),  64'd0);
        next_cycle();
        #2;
        check_eq("b_end_busy", 64'(b_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
